// File: rtl/crash_sequencer_pkg.sv
// Shared definitions for the crash-overlay game-state controller:
// state encoding, default game timing and the lives-counter width helper.
package crash_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_CRASH = 2'd2,
      ST_OVER  = 2'd3
   } state_e;

   localparam int unsigned DEF_LIVES        = 3;
   localparam int unsigned DEF_BLINK_FRAMES = 16;
   localparam int unsigned DEF_HOLD_FRAMES  = 120;

   function automatic int unsigned lives_width(input int unsigned lives);
      return $clog2(lives + 1);
   endfunction

endpackage

// File: rtl/crash_sequencer_if.sv
// Game-control bundle between the collision/button logic, the motion logic
// and the crash-text overlay.
interface crash_sequencer_if
   import crash_sequencer_pkg::*;
#(
   parameter int unsigned LIVES = DEF_LIVES
);
   localparam int unsigned LW = lives_width(LIVES);

   logic          tick_frame;
   logic          collision;
   logic          btn_start;
   logic          text_en;
   logic          game_run;
   logic          restart;
   logic [LW-1:0] lives;
   logic          game_over;
   logic [1:0]    state;

   modport master (
      output tick_frame, collision, btn_start,
      input  text_en, game_run, restart, lives, game_over, state
   );

   modport slave (
      input  tick_frame, collision, btn_start,
      output text_en, game_run, restart, lives, game_over, state
   );

endinterface

// File: rtl/crash_sequencer_frame_timer.sv
// Frame-tick counter with clear; tc_o flags the terminal count N-1 and the
// counter returns to 0 on the tick taken at terminal count.
module crash_sequencer_frame_timer #(
   parameter int unsigned N = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic tick_i,
   output logic tc_o
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == CW'(N - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (tick_i)
         cnt_d = tc_o ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/crash_sequencer.sv
// Game-state controller: sequences the blinking "Crash" overlay, freezes play
// around collisions, tracks lives and issues the one-cycle restart pulse.
module crash_sequencer
   import crash_sequencer_pkg::*;
#(
   parameter int unsigned LIVES        = DEF_LIVES,
   parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES,
   parameter int unsigned HOLD_FRAMES  = DEF_HOLD_FRAMES
) (
   input logic              clk,
   input logic              reset,
   crash_sequencer_if.slave bus
);

   localparam int unsigned LW = lives_width(LIVES);

   state_e        state_q, state_d;
   logic [LW-1:0] lives_q, lives_d;
   logic          phase_q, phase_d;
   logic          btn_q;
   logic          restart_q, restart_d;
   logic          text_en_q, text_en_d;
   logic          game_run_q, game_run_d;
   logic          game_over_q, game_over_d;
   logic          start_edge, crash_tick, timer_clr, hold_tc, blink_tc;

   assign start_edge = bus.btn_start & ~btn_q;
   assign crash_tick = bus.tick_frame & (state_q == ST_CRASH);
   // Timers sit at 0 outside CRASH, so entry always starts from a clean count.
   assign timer_clr  = (state_q != ST_CRASH);

   crash_sequencer_frame_timer #(.N(HOLD_FRAMES)) u_hold_timer (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (timer_clr),
      .tick_i (crash_tick),
      .tc_o   (hold_tc)
   );

   crash_sequencer_frame_timer #(.N(BLINK_FRAMES)) u_blink_timer (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (timer_clr),
      .tick_i (crash_tick),
      .tc_o   (blink_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         lives_q     <= LW'(LIVES);
         phase_q     <= 1'b0;
         btn_q       <= 1'b1;
         restart_q   <= 1'b0;
         text_en_q   <= 1'b0;
         game_run_q  <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         phase_q     <= phase_d;
         btn_q       <= bus.btn_start;
         restart_q   <= restart_d;
         text_en_q   <= text_en_d;
         game_run_q  <= game_run_d;
         game_over_q <= game_over_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lives_d   = lives_q;
      phase_d   = phase_q;
      restart_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d   = ST_PLAY;
               lives_d   = LW'(LIVES);
               restart_d = 1'b1;
            end
         end
         ST_PLAY: begin
            if (bus.collision) begin
               state_d = ST_CRASH;
               lives_d = (lives_q == '0) ? '0 : lives_q - LW'(1);
               phase_d = 1'b1;
            end
         end
         ST_CRASH: begin
            if (crash_tick) begin
               if (blink_tc)
                  phase_d = ~phase_q;
               if (hold_tc) begin
                  if (lives_q == '0) begin
                     state_d = ST_OVER;
                  end else begin
                     state_d   = ST_PLAY;
                     restart_d = 1'b1;
                  end
               end
            end
         end
         ST_OVER: begin
            if (start_edge) begin
               state_d   = ST_PLAY;
               lives_d   = LW'(LIVES);
               restart_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from next state so the registered copies line up with state_q.
   always_comb begin
      text_en_d   = 1'b0;
      game_run_d  = 1'b0;
      game_over_d = 1'b0;
      case (state_d)
         ST_PLAY:  game_run_d = 1'b1;
         ST_CRASH: text_en_d  = phase_d;
         ST_OVER: begin
            text_en_d   = 1'b1;
            game_over_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.state     = state_q;
   assign bus.lives     = lives_q;
   assign bus.restart   = restart_q;
   assign bus.text_en   = text_en_q;
   assign bus.game_run  = game_run_q;
   assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_crash_sequencer.sv
// Directed bench for crash_sequencer with a scoreboard queue of hand-computed
// expectations popped by a monitor on the falling clock edge.
module tb_crash_sequencer;
   import crash_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst;

   crash_sequencer_if #(.LIVES(2)) bus ();

   crash_sequencer #(
      .LIVES        (2),
      .BLINK_FRAMES (2),
      .HOLD_FRAMES  (4)
   ) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      int         due;
      logic [1:0] st;
      logic       te;
      logic       gr;
      logic       rs;
      logic [1:0] lv;
      logic       go;
   } exp_t;

   exp_t sb[$];
   int   pe_cnt = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always @(posedge clk) pe_cnt <= pe_cnt + 1;

   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due <= pe_cnt) begin
         e = sb.pop_front();
         n_chk++;
         if (e.due != pe_cnt || bus.state !== e.st || bus.text_en !== e.te ||
             bus.game_run !== e.gr || bus.restart !== e.rs ||
             bus.lives !== e.lv || bus.game_over !== e.go) begin
            n_fail++;
            $display("FAIL %s @%0d: got st=%0d te=%b run=%b rst=%b lives=%0d over=%b, want st=%0d te=%b run=%b rst=%b lives=%0d over=%b",
                     e.nm, pe_cnt, bus.state, bus.text_en, bus.game_run, bus.restart,
                     bus.lives, bus.game_over, e.st, e.te, e.gr, e.rs, e.lv, e.go);
         end
      end
   end

   // Queue the outputs expected after the coming rising edge, then advance one cycle.
   task automatic step(input string nm, input logic [1:0] st, input logic te,
                       input logic gr, input logic rs, input logic [1:0] lv,
                       input logic go);
      exp_t e;
      e.nm = nm; e.due = pe_cnt + 1;
      e.st = st; e.te = te; e.gr = gr; e.rs = rs; e.lv = lv; e.go = go;
      sb.push_back(e);
      @(negedge clk);
   endtask

   // Crash ticks 1..3 with an idle cycle after each; text_en runs 1,0,0.
   task automatic crash_ticks(input string nm, input logic [1:0] lv);
      logic pat [3];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.tick_frame = 1'b1;
         step($sformatf("%s_tick%0d", nm, i + 1), ST_CRASH, pat[i], 1'b0, 1'b0, lv, 1'b0);
         bus.tick_frame = 1'b0;
         step($sformatf("%s_gap%0d", nm, i + 1), ST_CRASH, pat[i], 1'b0, 1'b0, lv, 1'b0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.btn_start  = 1'b1;
      bus.tick_frame = 1'b0;
      bus.collision  = 1'b0;
      @(negedge clk);
      step("reset", ST_IDLE, 0, 0, 0, 2, 0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) step("btn_held_thru_reset", ST_IDLE, 0, 0, 0, 2, 0);
      bus.btn_start = 1'b0;
      step("btn_release", ST_IDLE, 0, 0, 0, 2, 0);
      bus.btn_start = 1'b1;
      step("start", ST_PLAY, 0, 1, 1, 2, 0);
      step("start_pulse_end", ST_PLAY, 0, 1, 0, 2, 0);
      bus.btn_start = 1'b0;
      step("play_idle", ST_PLAY, 0, 1, 0, 2, 0);

      for (int i = 0; i < 3; i++) begin
         bus.tick_frame = 1'b1;
         step("play_tick", ST_PLAY, 0, 1, 0, 2, 0);
         bus.tick_frame = 1'b0;
         step("play_tick_gap", ST_PLAY, 0, 1, 0, 2, 0);
      end
      bus.btn_start = 1'b1;
      step("play_btn_ignored", ST_PLAY, 0, 1, 0, 2, 0);
      bus.btn_start = 1'b0;
      step("play_btn_release", ST_PLAY, 0, 1, 0, 2, 0);

      bus.collision  = 1'b1;
      bus.tick_frame = 1'b1;
      step("crash1_entry", ST_CRASH, 1, 0, 0, 1, 0);
      bus.tick_frame = 1'b0;
      step("crash1_coll_held", ST_CRASH, 1, 0, 0, 1, 0);
      crash_ticks("crash1", 2'd1);
      bus.collision  = 1'b0;
      bus.tick_frame = 1'b1;
      step("crash1_resume", ST_PLAY, 0, 1, 1, 1, 0);
      bus.tick_frame = 1'b0;
      step("crash1_resume_end", ST_PLAY, 0, 1, 0, 1, 0);

      bus.collision = 1'b1;
      step("crash2_entry", ST_CRASH, 1, 0, 0, 0, 0);
      bus.collision = 1'b0;
      bus.btn_start = 1'b1;
      step("crash2_btn_ignored", ST_CRASH, 1, 0, 0, 0, 0);
      bus.btn_start = 1'b0;
      step("crash2_btn_release", ST_CRASH, 1, 0, 0, 0, 0);
      crash_ticks("crash2", 2'd0);
      bus.tick_frame = 1'b1;
      step("over_entry", ST_OVER, 1, 0, 0, 0, 1);
      bus.tick_frame = 1'b0;
      step("over_steady1", ST_OVER, 1, 0, 0, 0, 1);
      bus.tick_frame = 1'b1;
      step("over_steady_tick", ST_OVER, 1, 0, 0, 0, 1);
      bus.tick_frame = 1'b0;

      bus.btn_start = 1'b1;
      step("over_restart", ST_PLAY, 0, 1, 1, 2, 0);
      bus.btn_start = 1'b0;
      step("over_restart_end", ST_PLAY, 0, 1, 0, 2, 0);

      bus.collision = 1'b1;
      step("crash3_entry", ST_CRASH, 1, 0, 0, 1, 0);
      bus.collision  = 1'b0;
      bus.tick_frame = 1'b1;
      step("crash3_tick1", ST_CRASH, 1, 0, 0, 1, 0);
      bus.tick_frame = 1'b0;
      rst = 1'b1;
      step("reset_mid_crash", ST_IDLE, 0, 0, 0, 2, 0);
      rst = 1'b0;
      step("after_reset_idle", ST_IDLE, 0, 0, 0, 2, 0);

      bus.btn_start = 1'b1;
      step("start4", ST_PLAY, 0, 1, 1, 2, 0);
      bus.btn_start = 1'b0;
      step("start4_end", ST_PLAY, 0, 1, 0, 2, 0);
      bus.collision = 1'b1;
      step("crash4_entry", ST_CRASH, 1, 0, 0, 1, 0);
      bus.collision = 1'b0;
      crash_ticks("crash4", 2'd1);
      bus.tick_frame = 1'b1;
      rst = 1'b1;
      step("reset_drops_restart", ST_IDLE, 0, 0, 0, 2, 0);
      bus.tick_frame = 1'b0;
      rst = 1'b0;
      step("final_idle", ST_IDLE, 0, 0, 0, 2, 0);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
